crc_serial_encoder: RTL and testbench

Parametrised bit-serial CRC encoder with valid/ready handshakes on both sides. It accepts one DATA_W-bit data word plus its ADDR_W-bit address, and computes the CRC_W-bit remainder of data·x^CRC_W mod G(x) over DATA_W clock cycles, MSB first. It then presents the systematic codeword {data, crc} with the address until the downstream accepts it. It sits between the memory write port and the protected storage array, as the generic successor to the fixed 8/4-bit CRC encoder.

---
 rtl/crc_pkg.sv | 25 ++
 rtl/crc_lfsr_step.sv | 24 ++
 rtl/crc_serial_encoder.sv | 132 +++++++++++++
 tb/tb_crc_serial_encoder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc_pkg
// Brief    : Shared types, default polynomials and sizing helper for the CRC encoder/decoder.
// Revision : 1.0
// ============================================================================
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_e;

  localparam logic [3:0]  c_poly_crc4  = 4'h3;
  localparam logic [7:0]  c_poly_crc8  = 8'h07;
  localparam logic [15:0] c_poly_crc16 = 16'h1021;

  // Wide enough to hold DATA_W itself, so the counter never wraps within a word.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc_lfsr_step.sv
`default_nettype none
// ============================================================================
// Module   : crc_lfsr_step
// Brief    : Combinational single-bit LFSR update, shared by CRC encoder and decoder.
// Revision : 1.0
// ============================================================================
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int                CRC_W = 4,
  parameter logic [CRC_W-1:0]  POLY  = c_poly_crc4
) (
  input  logic [CRC_W-1:0] lfsr,
  input  logic             m,
  output logic [CRC_W-1:0] lfsr_next
);

  logic w_fb;

  assign w_fb      = lfsr[CRC_W-1] ^ m;
  assign lfsr_next = {lfsr[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);

endmodule
`default_nettype wire

// File: rtl/crc_serial_encoder.sv
`default_nettype none
// ============================================================================
// Module   : crc_serial_encoder
// Brief    : Bit-serial CRC encoder, emits {data, crc} with address. Option: CRC_ENC_INIT_ONES_EN.
// Revision : 1.0
// ============================================================================
module crc_serial_encoder
  import crc_pkg::*;
#(
  parameter int               DATA_W = 8,
  parameter int               ADDR_W = 4,
  parameter int               CRC_W  = 4,
  parameter logic [CRC_W-1:0] POLY   = c_poly_crc4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       data_in,
  input  logic [ADDR_W-1:0]       addr_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W+CRC_W-1:0] data_out,
  output logic [CRC_W-1:0]        crc_out,
  output logic [ADDR_W-1:0]       addr_out,
  output logic                    busy
);

  localparam int               CNT_W  = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(DATA_W - 1);

`ifdef CRC_ENC_INIT_ONES_EN
  localparam logic [CRC_W-1:0] c_lfsr_init = '1;
`else
  localparam logic [CRC_W-1:0] c_lfsr_init = '0;
`endif

  crc_state_e        r_state;
  crc_state_e        w_state_next;
  logic              w_accept;
  logic              w_shift_en;

  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_shift;
  logic [CRC_W-1:0]  r_lfsr;
  logic [CNT_W-1:0]  r_cnt;
  logic [CRC_W-1:0]  w_lfsr_next;

  crc_lfsr_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .lfsr      (r_lfsr),
    .m         (r_shift[DATA_W-1]),
    .lfsr_next (w_lfsr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake outputs decode from state alone; flush only gates the transitions.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_shift_en   = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          w_accept     = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (!flush) begin
          w_shift_en = 1'b1;
          if (r_cnt == c_last) begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (flush) begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_addr  <= '0;
      r_shift <= '0;
      r_lfsr  <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_data  <= data_in;
      r_addr  <= addr_in;
      r_shift <= data_in;
      r_lfsr  <= c_lfsr_init;
      r_cnt   <= '0;
    end else if (w_shift_en) begin
      r_shift <= r_shift << 1;
      r_lfsr  <= w_lfsr_next;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign data_out = {r_data, r_lfsr};
  assign crc_out  = r_lfsr;
  assign addr_out = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_crc_serial_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_serial_encoder
// Brief    : Directed checks of the default encoder plus a scoreboarded 16/8-bit stream.
// Revision : 1.0
// ============================================================================
module tb_crc_serial_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [7:0]  data_in;
  logic [3:0]  addr_in;
  logic        in_ready, out_valid, busy;
  logic [11:0] data_out;
  logic [3:0]  crc_out, addr_out;

  logic        b_flush = 1'b0;
  logic        b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_busy;
  logic [15:0] b_data_in;
  logic [3:0]  b_addr_in, b_addr_out;
  logic [23:0] b_data_out;
  logic [7:0]  b_crc_out;

  int n_run  = 0;
  int n_fail = 0;

`ifdef CRC_ENC_INIT_ONES_EN
  localparam logic [3:0] c_init_term = 4'h6;
`else
  localparam logic [3:0] c_init_term = 4'h0;
`endif

  crc_serial_encoder dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .addr_in(addr_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .crc_out(crc_out), .addr_out(addr_out), .busy(busy)
  );

  crc_serial_encoder #(.DATA_W(16), .ADDR_W(4), .CRC_W(8), .POLY(8'h07)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in), .addr_in(b_addr_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out),
    .crc_out(b_crc_out), .addr_out(b_addr_out), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Contribution of an all-ones preload: ones * x^16 mod G.
  function automatic logic [7:0] b_init_term();
    logic [7:0] r;
    r = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  // Long division of the augmented message {d, 8'h00} by x^8+x^2+x+1.
  function automatic logic [7:0] b_ref(input logic [15:0] d);
    logic [23:0] msg;
    logic [7:0]  r;
    logic        top;
    msg = {d, 8'h00};
    r   = 8'h00;
    for (int i = 23; i >= 0; i--) begin
      top = r[7];
      r   = {r[6:0], msg[i]};
      if (top) r = r ^ 8'h07;
    end
`ifdef CRC_ENC_INIT_ONES_EN
    r = r ^ b_init_term();
`endif
    return r;
  endfunction

  task automatic send(input logic [7:0] d, input logic [3:0] a);
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = d;
    addr_in  = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int          lat;
    logic        seen;
    logic [15:0] q_data[$];
    logic [3:0]  q_addr[$];
    logic [15:0] bd;
    logic [7:0]  bexp;
    int          got, cyc, last_acc;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0; addr_in = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_data_in = '0; b_addr_in = '0;

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_crc_out", crc_out, 0);
    chk("rst_addr_out", addr_out, 0);
    chk("b_rst_busy", b_busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic word
    out_ready = 1'b1;
    send(8'hA5, 4'h9);
    wait_valid(lat);
    chk("a5_latency", lat, 8);
    chk("a5_data_out", data_out, {8'hA5, 4'hB ^ c_init_term});
    chk("a5_crc_out", crc_out, 4'hB ^ c_init_term);
    chk("a5_addr_out", addr_out, 4'h9);
    chk("a5_busy", busy, 1);
    @(posedge clk); #1;
    chk("a5_in_ready_after_hs", in_ready, 1);
    chk("a5_out_valid_after_hs", out_valid, 0);

    // All-zero word exposes the LFSR preload
    send(8'h00, 4'h3);
    wait_valid(lat);
    chk("zero_latency", lat, 8);
    chk("zero_data_out", data_out, {8'h00, c_init_term});
    @(posedge clk); #1;

    // Backpressure with a competing in_valid
    out_ready = 1'b0;
    send(8'h5A, 4'h5);
    wait_valid(lat);
    chk("bp_latency", lat, 8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = 8'hFF;
      addr_in  = 4'h0;
      @(posedge clk); #1;
      chk("bp_data_out", data_out, {8'h5A, 4'hF ^ c_init_term});
      chk("bp_addr_out", addr_out, 4'h5);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after_hs", in_ready, 1);
    chk("bp_out_valid_after_hs", out_valid, 0);
    @(posedge clk); #1;
    chk("bp_no_ghost_accept", busy, 0);

    // Flush three cycles into SHIFT
    send(8'hA5, 4'h2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_busy", busy, 0);
    @(negedge clk);
    flush = 1'b0;
    seen  = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_out_valid", seen, 0);

    // Flush beats a simultaneous in_valid in IDLE
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'hFF;
    @(posedge clk); #1;
    chk("flush_blocks_accept", busy, 0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    send(8'hA5, 4'h7);
    wait_valid(lat);
    chk("post_flush_latency", lat, 8);
    chk("post_flush_crc", crc_out, 4'hB ^ c_init_term);
    chk("post_flush_addr", addr_out, 4'h7);
    @(posedge clk); #1;

    // Asynchronous reset mid-SHIFT
    send(8'h5A, 4'hC);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data_out", data_out, 0);
    chk("arst_crc_out", crc_out, 0);
    chk("arst_addr_out", addr_out, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'hA5, 4'h9);
    wait_valid(lat);
    chk("recover_latency", lat, 8);
    chk("recover_data_out", data_out, {8'hA5, 4'hB ^ c_init_term});
    chk("recover_addr", addr_out, 4'h9);
    @(posedge clk); #1;

    // Random stream on the 16/8-bit instance
    got      = 0;
    cyc      = 0;
    last_acc = -1;
    while (got < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      b_out_ready = 1'($urandom_range(0, 1));
      if (b_out_valid && b_out_ready) begin
        if (q_data.size() == 0) begin
          chk("b_unexpected_output", 1, 0);
        end else begin
          bd   = q_data.pop_front();
          bexp = b_ref(bd);
          chk("b_crc_out", b_crc_out, bexp);
          chk("b_data_out", b_data_out, {bd, bexp});
          chk("b_addr_out", b_addr_out, q_addr.pop_front());
          got++;
        end
      end
      if (b_in_ready) begin
        b_in_valid = 1'b1;
        b_data_in  = 16'($urandom);
        b_addr_in  = 4'($urandom);
        q_data.push_back(b_data_in);
        q_addr.push_back(b_addr_in);
        if (last_acc >= 0) chk("b_min_ii", (cyc - last_acc) >= 18, 1);
        last_acc = cyc;
      end else begin
        b_in_valid = 1'b0;
      end
    end
    chk("b_stream_count", got, 1000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
